// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Package  : link_pkg
// Brief    : Shared defaults and FSM state encoding for the link deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

    localparam int unsigned c_word_w_default      = 16;
    localparam int unsigned c_frame_words_default = 8;
    localparam logic [15:0] c_sync_word_default   = 16'hD391;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } link_state_e;

endpackage : link_pkg
`default_nettype wire

// File: rtl/sync_popcount.sv
`default_nettype none
// ============================================================================
// Module   : sync_popcount
// Brief    : Hamming distance between a received word and the sync pattern.
// Revision : 1.0 - initial release
// ============================================================================
module sync_popcount
    import link_pkg::*;
#(
    parameter int unsigned          WORD_W    = c_word_w_default,
    parameter logic [WORD_W-1:0]    SYNC_WORD = WORD_W'(c_sync_word_default),
    parameter int unsigned          DIST_W    = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] i_data,
    output logic [DIST_W-1:0] o_distance
);

    logic [WORD_W-1:0] w_diff;

    assign w_diff = i_data ^ SYNC_WORD;

    always_comb begin
        o_distance = '0;
        for (int i = 0; i < WORD_W; i++) begin
            o_distance = o_distance + DIST_W'(w_diff[i]);
        end
    end

endmodule : sync_popcount
`default_nettype wire

// File: rtl/link_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : link_deserializer
// Brief    : Serial frame-sync hunter and payload word deserializer with
//            flywheel lock. Build option LINK_DESER_ERRCNT_EN enables the
//            saturating sync-slot bit-error counter (sync_popcount).
// Revision : 1.0 - initial release
// ============================================================================
module link_deserializer
    import link_pkg::*;
#(
    parameter int unsigned       WORD_W      = c_word_w_default,
    parameter logic [WORD_W-1:0] SYNC_WORD   = WORD_W'(c_sync_word_default),
    parameter int unsigned       FRAME_WORDS = c_frame_words_default,
    parameter int unsigned       MISS_LIMIT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              frame_start,
    output logic              locked,
    output logic [15:0]       sync_err_cnt
);

    localparam int unsigned c_cnt_w  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned c_idx_w  = $clog2(FRAME_WORDS + 1);
    localparam int unsigned c_miss_w = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(WORD_W - 1);
    localparam logic [c_idx_w-1:0]  c_sync_slot = c_idx_w'(FRAME_WORDS);
    localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(MISS_LIMIT - 1);

    link_state_e         r_state;
    link_state_e         w_next_state;
    logic [WORD_W-1:0]   r_sr;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_idx_w-1:0]  r_word_idx;
    logic [c_miss_w-1:0] r_miss_cnt;
    logic [WORD_W-1:0]   r_word_out;
    logic                r_word_valid;
    logic                r_frame_start;

    logic w_sync_match;
    logic w_slot_done;
    logic w_sync_slot;
    logic w_word_valid_d;
    logic w_frame_start_d;
    logic w_miss_inc;
    logic w_miss_clr;

    assign w_sync_match = (r_sr == SYNC_WORD);
    assign w_slot_done  = (r_bit_cnt == c_bit_last);
    assign w_sync_slot  = (r_word_idx == c_sync_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_word_valid_d  = 1'b0;
        w_frame_start_d = 1'b0;
        w_miss_inc      = 1'b0;
        w_miss_clr      = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_miss_clr = 1'b1;
                if (w_sync_match) begin
                    w_next_state = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_slot_done && w_sync_slot) begin
                    if (w_sync_match) begin
                        w_next_state    = ST_LOCKED;
                        w_frame_start_d = 1'b1;
                    end else begin
                        w_next_state = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_slot_done) begin
                    if (!w_sync_slot) begin
                        w_word_valid_d = 1'b1;
                    end else if (w_sync_match) begin
                        w_frame_start_d = 1'b1;
                        w_miss_clr      = 1'b1;
                    end else if (r_miss_cnt == c_miss_last) begin
                        w_next_state = ST_HUNT;
                        w_miss_clr   = 1'b1;
                    end else begin
                        w_miss_inc = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_HUNT;
        endcase
    end

    // Counters are held at zero while hunting so a match starts slot 0 cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_word_idx    <= '0;
            r_miss_cnt    <= '0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_sr          <= {r_sr[WORD_W-2:0], serial_in};
            r_word_valid  <= w_word_valid_d;
            r_frame_start <= w_frame_start_d;
            if (w_word_valid_d) begin
                r_word_out <= r_sr;
            end
            if (r_state == ST_HUNT) begin
                r_bit_cnt  <= '0;
                r_word_idx <= '0;
            end else if (w_slot_done) begin
                r_bit_cnt  <= '0;
                r_word_idx <= w_sync_slot ? '0 : r_word_idx + 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_miss_clr) begin
                r_miss_cnt <= '0;
            end else if (w_miss_inc) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == ST_LOCKED);

`ifdef LINK_DESER_ERRCNT_EN
    localparam int unsigned c_pop_w = $clog2(WORD_W + 1);

    logic [c_pop_w-1:0] w_sync_dist;
    logic [16:0]        w_err_sum;
    logic               w_err_acc;
    logic [15:0]        r_sync_err_cnt;

    sync_popcount #(
        .WORD_W    (WORD_W),
        .SYNC_WORD (SYNC_WORD),
        .DIST_W    (c_pop_w)
    ) u_sync_popcount (
        .i_data     (r_sr),
        .o_distance (w_sync_dist)
    );

    assign w_err_acc = (r_state == ST_LOCKED) && w_slot_done && w_sync_slot;
    assign w_err_sum = {1'b0, r_sync_err_cnt} + 17'(w_sync_dist);

    // Carry out of the 16-bit sum means the counter has saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_err_cnt <= '0;
        end else if (w_err_acc) begin
            r_sync_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign sync_err_cnt = r_sync_err_cnt;
`else
    assign sync_err_cnt = 16'h0000;
`endif

endmodule : link_deserializer
`default_nettype wire

// File: tb/tb_link_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_deserializer
// Brief    : Scoreboard bench for link_deserializer with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_deserializer;

    localparam logic [15:0] c_sync = 16'hD391;
`ifdef LINK_DESER_ERRCNT_EN
    localparam logic [15:0] c_err_s5 = 16'd3;
`else
    localparam logic [15:0] c_err_s5 = 16'd0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        serial_in = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        frame_start;
    logic        locked;
    logic [15:0] sync_err_cnt;

    link_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .frame_start  (frame_start),
        .locked       (locked),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec     = 0;
    int          n_err     = 0;
    bit          mon_en    = 1'b0;
    logic        locked_prev = 1'b0;
    int unsigned fs_cnt    = 0;
    int unsigned fs_last   = 0;
    int unsigned rise_cnt  = 0;
    int unsigned rise_cyc  = 0;
    int unsigned fall_cyc  = 0;
    int unsigned last_cyc  = 0;
    int unsigned n_mark    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and logs lock/frame events.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (word_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word_valid", {31'b0, word_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_out", {16'b0, word_out}, {16'b0, e.data});
                    check("word_latency", cyc, e.due);
                end
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_last = cyc;
            end
            if (locked !== locked_prev) begin
                if (locked === 1'b1) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                end else begin
                    fall_cyc = cyc;
                end
                locked_prev = locked;
            end
        end
    end

    task automatic send_word(input logic [15:0] w, input bit expect_out);
        for (int i = 15; i >= 0; i--) begin
            serial_in = w[i];
            @(posedge clk);
            #1;
        end
        last_cyc = cyc;
        if (expect_out) exp_q.push_back('{data: w, due: cyc + 1});
    endtask

    task automatic send_payload(input logic [15:0] base, input bit expect_out);
        for (int k = 1; k <= 8; k++) send_word(base + 16'(k), expect_out);
    endtask

    initial begin
        rst = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_word_out", {16'b0, word_out}, 32'd0);
        check("reset_word_valid", {31'b0, word_valid}, 32'd0);
        check("reset_frame_start", {31'b0, frame_start}, 32'd0);
        check("reset_locked", {31'b0, locked}, 32'd0);
        check("reset_sync_err_cnt", {16'b0, sync_err_cnt}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Lock: random prefix, sync, verify frame, sync
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        send_word(c_sync, 1'b0);
        send_payload(16'h0000, 1'b0);
        send_word(c_sync, 1'b0);
        n_mark = last_cyc;
        send_payload(16'h0000, 1'b1);
        check("s1_lock_rise_cycle", rise_cyc, n_mark + 1);
        check("s1_frame_start_count", fs_cnt, 32'd1);
        check("s1_frame_start_cycle", fs_last, n_mark + 1);
        send_word(c_sync, 1'b0);

        // Payload word aliasing the sync pattern
        send_word(16'hA501, 1'b1);
        send_word(16'hA502, 1'b1);
        send_word(c_sync,   1'b1);
        for (int k = 4; k <= 8; k++) send_word(16'hA500 + 16'(k), 1'b1);
        check("s6_no_alias_frame_start", fs_cnt, 32'd2);
        send_word(c_sync, 1'b0);
        send_payload(16'h5A00, 1'b1);
        check("s6_frame_start_count", fs_cnt, 32'd3);

        // Two misses keep lock, a good sync clears the miss count
        send_word(16'h0000, 1'b0);
        send_payload(16'h3C00, 1'b1);
        send_word(16'hD390, 1'b0);
        send_payload(16'h3C10, 1'b1);
        check("s3_locked_after_2_misses", {31'b0, locked}, 32'd1);
        send_word(c_sync, 1'b0);
        send_payload(16'h3C20, 1'b1);
        send_word(16'h1111, 1'b0);
        send_payload(16'h3C30, 1'b1);
        send_word(16'h2222, 1'b0);
        send_payload(16'h3C40, 1'b1);
        send_word(16'h4444, 1'b0);
        n_mark = last_cyc;
        send_payload(16'h0000, 1'b0);
        check("s3_lock_fall_cycle", fall_cyc, n_mark + 1);
        check("s3_locked_after_3_misses", {31'b0, locked}, 32'd0);
        check("s3_frame_start_count", fs_cnt, 32'd4);

        // Failed verify
        send_word(c_sync, 1'b0);
        send_payload(16'h0000, 1'b0);
        send_word(16'hD390, 1'b0);
        send_payload(16'h0000, 1'b0);
        check("s2_locked", {31'b0, locked}, 32'd0);
        check("s2_lock_rise_count", rise_cnt, 32'd1);

        // Reset sampled on the last bit of payload word 4
        send_word(c_sync, 1'b0);
        send_payload(16'h0000, 1'b0);
        send_word(c_sync, 1'b0);
        send_word(16'hB001, 1'b1);
        send_word(16'hB002, 1'b1);
        send_word(16'hB003, 1'b1);
        for (int i = 15; i >= 1; i--) begin
            serial_in = 1'(16'hB004 >> i);
            @(posedge clk);
            #1;
        end
        serial_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s4_rst_word_out", {16'b0, word_out}, 32'd0);
        check("s4_rst_word_valid", {31'b0, word_valid}, 32'd0);
        check("s4_rst_frame_start", {31'b0, frame_start}, 32'd0);
        check("s4_rst_locked", {31'b0, locked}, 32'd0);
        check("s4_rst_sync_err_cnt", {16'b0, sync_err_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s4_post_rst_word_valid", {31'b0, word_valid}, 32'd0);
        send_word(c_sync, 1'b0);
        send_payload(16'h0000, 1'b0);
        check("s4_not_locked_before_2nd_sync", {31'b0, locked}, 32'd0);
        send_word(c_sync, 1'b0);
        n_mark = last_cyc;
        send_payload(16'hC000, 1'b1);
        check("s4_relock_cycle", rise_cyc, n_mark + 1);
        check("s4_lock_rise_count", rise_cnt, 32'd3);
        send_word(c_sync, 1'b0);

        // Sync-slot bit errors: 2 flipped, then 1 flipped
        send_payload(16'hE000, 1'b1);
        send_word(c_sync ^ 16'h0101, 1'b0);
        send_payload(16'hE010, 1'b1);
        send_word(c_sync ^ 16'h0010, 1'b0);
        send_payload(16'hE020, 1'b1);
        check("s5_sync_err_cnt", {16'b0, sync_err_cnt}, {16'b0, c_err_s5});
        check("s5_locked", {31'b0, locked}, 32'd1);
        send_word(c_sync, 1'b0);
`ifdef LINK_DESER_ERRCNT_EN
        force dut.r_sync_err_cnt = 16'hFFFE;
        #1;
        release dut.r_sync_err_cnt;
        send_payload(16'hE030, 1'b1);
        send_word(c_sync ^ 16'h0007, 1'b0);
        send_payload(16'hE040, 1'b1);
        check("s5_err_cnt_saturated", {16'b0, sync_err_cnt}, 32'h0000_FFFF);
        send_word(c_sync, 1'b0);
        send_payload(16'hE050, 1'b1);
        check("s5_err_cnt_held", {16'b0, sync_err_cnt}, 32'h0000_FFFF);
        send_word(c_sync, 1'b0);
`endif
        send_payload(16'hF000, 1'b1);
        send_word(c_sync, 1'b0);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("final_locked", {31'b0, locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_link_deserializer
`default_nettype wire
